// File: rtl/wb_spi_slave_if.sv
// ---------------------------------------------------------------------------
// wb_spi_slave_if -- Wishbone classic slave bus bundle for wb_spi_slave.
//
// Signals (directions seen from the slave):
//   wb_adr_i [31:0]  byte address; register index is taken from bits [5:2]
//   wb_dat_i [31:0]  write data
//   wb_dat_o [31:0]  read data, valid while wb_ack_o is high
//   wb_sel_i [3:0]   byte selects (accepted, not used by the slave)
//   wb_cyc_i         bus cycle in progress
//   wb_stb_i         strobe: this slave is addressed
//   wb_we_i          1 = write, 0 = read
//   wb_ack_o         cycle acknowledge
//
// Modports: master (drives the request side), slave (drives data/ack back).
// ---------------------------------------------------------------------------
interface wb_spi_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spi_slave.sv
// ---------------------------------------------------------------------------
// wb_spi_slave -- SPI slave (sck idle high, sample on falling edge, shift out
// on rising edge, MSB first) with a Wishbone register interface.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-low reset
//   wb           Wishbone slave bundle (wb_spi_slave_if.slave)
//   spi_sck      serial clock from the external master (asynchronous)
//   spi_mosi     serial data from the master (asynchronous)
//   spi_cs       chip select, active low (asynchronous)
//   spi_miso     serial data to the master (tx_shift[7])
//   spi_miso_oe  output enable, high while chip select is seen low
//
// Registers (index = wb_adr_i[5:2]):
//   0 RXDATA  read: oldest received byte in [7:0] and pop; 0 when empty
//   1 STATUS  read: {27'b0, tx_udr, cs_active, tx_empty, rx_ovr, rx_avail}
//   2 TXDATA  write: [7:0] into the TX holding register, marks it valid
//   3 CONTROL write: bit0 clears rx_ovr, bit1 clears tx_udr
//   4-15      acknowledged, no effect, read as 0
//
// Configuration macro WB_SPI_SLAVE_FIFO_EN:
//   defined   -> RX buffer is a 4-entry FIFO
//   undefined -> RX buffer is a single byte register with a valid flag
// ---------------------------------------------------------------------------
module wb_spi_slave (
  input  logic          clk,
  input  logic          reset,
  wb_spi_slave_if.slave wb,
  input  logic          spi_sck,
  input  logic          spi_mosi,
  input  logic          spi_cs,
  output logic          spi_miso,
  output logic          spi_miso_oe
);

  typedef enum logic [3:0] {
    REG_RXDATA  = 4'd0,
    REG_STATUS  = 4'd1,
    REG_TXDATA  = 4'd2,
    REG_CONTROL = 4'd3
  } reg_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic       sck_s1_q, sck_s2_q, sck_prev_q;
  logic       cs_s1_q, cs_s2_q, cs_prev_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [1:0] sync_vld_q, sync_vld_d;
  logic       armed_q, armed_d;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;   // first seven bits of the byte in flight
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       tx_udr_q, tx_udr_d;
  logic       ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

`ifdef WB_SPI_SLAVE_FIFO_EN
  logic [7:0] rx_mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
`else
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_vld_q, rx_vld_d;
`endif

  // -------------------------------------------------------------------------
  // Edge detection on the synchronized SPI inputs
  // -------------------------------------------------------------------------
  logic sck_rise, sck_fall, cs_fall, cs_rise, cs_active;

  assign sck_rise = ~sck_prev_q &  sck_s2_q;
  assign sck_fall =  sck_prev_q & ~sck_s2_q;

  // The synchronizers come out of reset pretending to be idle. If the master
  // still holds cs low after reset, that fake high would look like a fresh
  // select; armed_q only rises once a real high has been seen, so the slave
  // rejoins on the next genuine cs falling edge.
  assign cs_active = armed_q & ~cs_s2_q;
  assign cs_fall   = armed_q &  cs_prev_q & ~cs_s2_q;
  assign cs_rise   = ~cs_prev_q & cs_s2_q;

  assign spi_miso    = tx_shift_q[7];
  assign spi_miso_oe = cs_active;

  logic       bit_done;
  logic [7:0] rx_byte;
  logic       tx_load;
  logic       udr_set;

  assign bit_done = sck_fall & cs_active & (bit_cnt_q == 3'd7);
  assign rx_byte  = {rx_shift_q, mosi_s2_q};
  assign tx_load  = cs_fall | bit_done;
  assign udr_set  = tx_load & ~hold_vld_q;

  // -------------------------------------------------------------------------
  // Wishbone decode
  // -------------------------------------------------------------------------
  logic [3:0] reg_idx;
  logic       access, rd_en, wr_en;
  logic       pop_req, hold_wr, ctrl_wr;

  assign reg_idx = wb.wb_adr_i[5:2];
  // A request is acted on only in the cycle before its ack, so a master that
  // holds stb through the ack cycle is not serviced twice.
  assign access  = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign rd_en   = access & ~wb.wb_we_i;
  assign wr_en   = access &  wb.wb_we_i;
  assign hold_wr = wr_en & (reg_idx == REG_TXDATA);
  assign ctrl_wr = wr_en & (reg_idx == REG_CONTROL);

  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_q;
  assign wb.wb_dat_o = dat_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, wb.wb_sel_i, wb.wb_adr_i[31:6], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:8]};

  // -------------------------------------------------------------------------
  // RX buffer view
  // -------------------------------------------------------------------------
  logic       rx_avail, rx_full, push_ok, ovr_set;
  logic [7:0] rx_head;

`ifdef WB_SPI_SLAVE_FIFO_EN
  assign rx_avail = (rx_cnt_q != 3'd0);
  assign rx_full  = (rx_cnt_q == 3'd4);
  assign rx_head  = rx_mem_q[rd_ptr_q];
`else
  assign rx_avail = rx_vld_q;
  assign rx_full  = rx_vld_q;
  assign rx_head  = rx_data_q;
`endif

  assign pop_req = rd_en & (reg_idx == REG_RXDATA) & rx_avail;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push_ok = bit_done & (~rx_full | pop_req);
  assign ovr_set = bit_done &  rx_full & ~pop_req;

  // -------------------------------------------------------------------------
  // Read data mux
  // -------------------------------------------------------------------------
  logic [31:0] rdata;

  always_comb begin
    rdata = 32'h0;
    case (reg_idx)
      REG_RXDATA: rdata = rx_avail ? {24'h0, rx_head} : 32'h0;
      REG_STATUS: rdata = {27'h0, tx_udr_q, cs_active, ~hold_vld_q, rx_ovr_q, rx_avail};
      default:    rdata = 32'h0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sync_vld_d = {sync_vld_q[0], 1'b1};
    armed_d    = armed_q | (sync_vld_q[1] & cs_s2_q);

    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;

    // Deselect abandons any partial byte; buffers and flags are untouched.
    if (cs_rise) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 7'h0;
    end else if (sck_fall && cs_active) begin
      bit_cnt_d  = bit_cnt_q + 3'd1;
      rx_shift_d = rx_byte[6:0];
    end

    if (tx_load) begin
      if (hold_vld_q) begin
        tx_shift_d = hold_q;
        hold_vld_d = 1'b0;
      end else begin
        tx_shift_d = 8'hFF;
      end
    end else if (sck_rise && cs_active && bit_cnt_q != 3'd0) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b1};
    end

    // A write coinciding with a load lands after it: the load took the old
    // value above, the new one stays pending.
    if (hold_wr) begin
      hold_d     = wb.wb_dat_i[7:0];
      hold_vld_d = 1'b1;
    end

    // Set wins over a same-cycle clear so no event is lost.
    rx_ovr_d = (rx_ovr_q & ~(ctrl_wr & wb.wb_dat_i[0])) | ovr_set;
    tx_udr_d = (tx_udr_q & ~(ctrl_wr & wb.wb_dat_i[1])) | udr_set;

    ack_d = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    dat_d = rd_en ? rdata : 32'h0;

`ifdef WB_SPI_SLAVE_FIFO_EN
    wr_ptr_d = push_ok ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop_req ? rd_ptr_q + 2'd1 : rd_ptr_q;
    rx_cnt_d = rx_cnt_q + {2'b0, push_ok} - {2'b0, pop_req};
`else
    rx_data_d = rx_data_q;
    rx_vld_d  = rx_vld_q;
    if (push_ok) begin
      rx_data_d = rx_byte;
      rx_vld_d  = 1'b1;
    end else if (pop_req) begin
      rx_vld_d  = 1'b0;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_s1_q   <= 1'b1;
      sck_s2_q   <= 1'b1;
      sck_prev_q <= 1'b1;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_prev_q  <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 7'h0;
      tx_shift_q <= 8'hFF;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_udr_q   <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
`ifdef WB_SPI_SLAVE_FIFO_EN
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      rx_cnt_q   <= 3'd0;
`else
      rx_data_q  <= 8'h00;
      rx_vld_q   <= 1'b0;
`endif
    end else begin
      sck_s1_q   <= spi_sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      cs_s1_q    <= spi_cs;
      cs_s2_q    <= cs_s1_q;
      cs_prev_q  <= cs_s2_q;
      mosi_s1_q  <= spi_mosi;
      mosi_s2_q  <= mosi_s1_q;
      sync_vld_q <= sync_vld_d;
      armed_q    <= armed_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_udr_q   <= tx_udr_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
`ifdef WB_SPI_SLAVE_FIFO_EN
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_cnt_q   <= rx_cnt_d;
`else
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
`endif
    end
  end

`ifdef WB_SPI_SLAVE_FIFO_EN
  // NOTE: the FIFO storage has no reset; emptiness is defined by the pointers
  // and count, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rx_mem_q[wr_ptr_q] <= rx_byte;
    end
  end
`endif

endmodule

// File: tb/tb_wb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_spi_slave -- directed bench for wb_spi_slave. Acts as Wishbone master
// and SPI master (sck idle high, mosi changed after rising edge, miso sampled
// at falling edge). Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_wb_spi_slave;

  localparam int HALF = 6;   // sck half-period in clk cycles

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic spi_sck = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_cs = 1'b1;
  logic spi_miso;
  logic spi_miso_oe;

  int passed = 0;
  int total  = 0;

  wb_spi_slave_if bus ();

  wb_spi_slave dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (bus),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_cs      (spi_cs),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_access(input logic [3:0] idx, input logic we,
                           input logic [31:0] wdata, output logic [31:0] rdata);
    bit got;
    got   = 1'b0;
    rdata = 32'h0;
    @(negedge clk);
    bus.wb_adr_i = {26'd0, idx, 2'b00};
    bus.wb_dat_i = wdata;
    bus.wb_we_i  = we;
    bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o) begin
        got   = 1'b1;
        rdata = bus.wb_dat_o;
      end
    end
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [3:0] idx, input logic [31:0] wdata);
    logic [31:0] dummy;
    wb_access(idx, 1'b1, wdata, dummy);
  endtask

  task automatic wb_read_check(input string tag, input logic [3:0] idx,
                               input logic [31:0] exp);
    logic [31:0] rd;
    wb_access(idx, 1'b0, 32'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    wait_clk(2 * HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    spi_cs = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      wait_clk(HALF);
      spi_sck = 1'b0;
      rx[7-i] = spi_miso;
      wait_clk(HALF);
      spi_sck = 1'b1;
    end
    wait_clk(HALF);
  endtask

  logic [7:0] miso_byte;

  initial begin
    bus.wb_adr_i = 32'h0;
    bus.wb_dat_i = 32'h0;
    bus.wb_sel_i = 4'h0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;

    // Reset state, with a request held on the bus.
    wait_clk(4);
    check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    check("rst_miso", {31'd0, spi_miso}, 32'd1);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    reset = 1'b1;
    wait_clk(4);
    wb_read_check("rst_status", 4'd1, 32'h04);

    // Basic exchange: slave sends A5, master sends 3C.
    wb_write(4'd2, 32'hA5);
    wb_read_check("t1_status_txfull", 4'd1, 32'h00);
    cs_begin();
    check("t1_oe", {31'd0, spi_miso_oe}, 32'd1);
    wb_read_check("t1_status_sel", 4'd1, 32'h0C);
    spi_xfer(8'h3C, 8, miso_byte);
    check("t1_miso", {24'd0, miso_byte}, 32'hA5);
    cs_end();
    wb_read_check("t1_status_avail", 4'd1, 32'h15);
    wb_read_check("t1_rxdata", 4'd0, 32'h3C);
    wb_read_check("t1_status_after", 4'd1, 32'h14);
    wb_write(4'd3, 32'h2);
    wb_read_check("t1_status_clr", 4'd1, 32'h04);

    // Two bytes with no second TX byte queued: underrun sends FF.
    wb_write(4'd2, 32'h5A);
    cs_begin();
    spi_xfer(8'h11, 8, miso_byte);
    check("t2_miso0", {24'd0, miso_byte}, 32'h5A);
    wb_read_check("t2_rx0", 4'd0, 32'h11);
    wb_read_check("t2_status_mid", 4'd1, 32'h1C);
    spi_xfer(8'h22, 8, miso_byte);
    check("t2_miso1", {24'd0, miso_byte}, 32'hFF);
    cs_end();
    wb_read_check("t2_status_udr", 4'd1, 32'h15);
    wb_read_check("t2_rx1", 4'd0, 32'h22);
    wb_write(4'd3, 32'h2);
    wb_read_check("t2_status_clr", 4'd1, 32'h04);

    // Overflow: five bytes with nothing read.
    cs_begin();
    for (int b = 1; b <= 5; b++) spi_xfer(b[7:0], 8, miso_byte);
    cs_end();
    wb_read_check("t3_status_ovr", 4'd1, 32'h17);
`ifdef WB_SPI_SLAVE_FIFO_EN
    wb_read_check("t3_rx1", 4'd0, 32'h01);
    wb_read_check("t3_rx2", 4'd0, 32'h02);
    wb_read_check("t3_rx3", 4'd0, 32'h03);
    wb_read_check("t3_rx4", 4'd0, 32'h04);
`else
    wb_read_check("t3_rx1", 4'd0, 32'h01);
`endif
    wb_read_check("t3_rx_empty", 4'd0, 32'h00);
    wb_write(4'd3, 32'h3);
    wb_read_check("t3_status_clr", 4'd1, 32'h04);

    // Partial byte discarded by deselect, then a full byte.
    cs_begin();
    spi_xfer(8'hF0, 4, miso_byte);
    cs_end();
    wb_read_check("t4_status_partial", 4'd1, 32'h14);
    cs_begin();
    spi_xfer(8'h81, 8, miso_byte);
    cs_end();
    wb_read_check("t4_status", 4'd1, 32'h15);
    wb_read_check("t4_rx", 4'd0, 32'h81);
    wb_read_check("t4_rx_empty", 4'd0, 32'h00);
    wb_write(4'd3, 32'h3);

    // Unmapped addresses: no effect, read as zero.
    wb_write(4'd5, 32'hFFFF_FFFF);
    wb_read_check("t5_unmapped_rd", 4'd7, 32'h0);
    wb_read_check("t5_status", 4'd1, 32'h04);

    // Reset in the middle of a byte, then a clean transfer.
    wb_write(4'd2, 32'hC3);
    cs_begin();
    spi_xfer(8'hAA, 5, miso_byte);
    reset = 1'b0;
    wait_clk(4);
    check("t6_rst_miso", {31'd0, spi_miso}, 32'd1);
    check("t6_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("t6_rst_dat", bus.wb_dat_o, 32'd0);
    reset = 1'b1;
    wait_clk(4);
    check("t6_oe_unarmed", {31'd0, spi_miso_oe}, 32'd0);
    wb_read_check("t6_status", 4'd1, 32'h04);
    spi_cs = 1'b1;
    wait_clk(2 * HALF);
    wb_write(4'd2, 32'h96);
    cs_begin();
    spi_xfer(8'h55, 8, miso_byte);
    check("t6_miso", {24'd0, miso_byte}, 32'h96);
    cs_end();
    wb_read_check("t6_rx", 4'd0, 32'h55);
    wb_read_check("t6_status_end", 4'd1, 32'h14);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
